// File: rtl/alu_div_sequencer.sv
// Unsigned 32-bit restoring divider that does all of its subtraction through an
// external ALU, one quotient bit per LOAD/WAIT pass.
//
// state | meaning
// IDLE  | ready for a request, last results held
// LOAD  | present {rem, next dividend bit} - divisor to the ALU
// WAIT  | hold ALU inputs ALU_WAIT cycles, capture on the last one
// DONE  | result valid, waiting for out_ready
module alu_div_sequencer #(
    parameter int unsigned ALU_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [2:0]  alu_command,
    input  logic [31:0] alu_result,
    input  logic        alu_carryout
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;

    localparam logic [2:0] CMD_SUB   = 3'd1;
    localparam logic [3:0] WAIT_LOAD = 4'(ALU_WAIT - 1);

    state_t      state, state_nxt;
    logic [31:0] dvd, dsr, rem, q;
    logic [4:0]  bit_idx;
    logic [3:0]  wait_cnt;
    logic        rem_msb;
    logic        take_sub;
    logic [31:0] rem_cap, q_cap;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // A set pre-shift MSB means the true partial remainder is >= 2^32, so the
    // subtraction must be taken even though the ALU reports a borrow.
    assign take_sub = alu_carryout || rem_msb;
    assign rem_cap  = take_sub ? alu_result : alu_operandA;
    assign q_cap    = q | ({31'b0, take_sub} << bit_idx);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = (divisor == 32'd0) ? DONE : LOAD;
            LOAD: state_nxt = WAIT;
            WAIT: if (wait_cnt == 4'd0) state_nxt = (bit_idx == 5'd0) ? DONE : LOAD;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            dvd          <= '0;
            dsr          <= '0;
            rem          <= '0;
            q            <= '0;
            bit_idx      <= '0;
            wait_cnt     <= '0;
            rem_msb      <= 1'b0;
            quotient     <= '0;
            remainder    <= '0;
            div_by_zero  <= 1'b0;
            alu_operandA <= '0;
            alu_operandB <= '0;
            alu_command  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        alu_command <= CMD_SUB;
                        div_by_zero <= 1'b0;
                        if (divisor == 32'd0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            dvd     <= dividend;
                            dsr     <= divisor;
                            rem     <= '0;
                            q       <= '0;
                            bit_idx <= 5'd31;
                        end
                    end
                end
                LOAD: begin
                    alu_operandA <= {rem[30:0], dvd[bit_idx]};
                    alu_operandB <= dsr;
                    alu_command  <= CMD_SUB;
                    rem_msb      <= rem[31];
                    wait_cnt     <= WAIT_LOAD;
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        rem <= rem_cap;
                        q   <= q_cap;
                        if (bit_idx == 5'd0) begin
                            quotient  <= q_cap;
                            remainder <= rem_cap;
                        end else begin
                            bit_idx <= bit_idx - 5'd1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_sequencer.sv
// Bench for alu_div_sequencer: two instances (ALU_WAIT=1 and 3) each with a
// behavioural 32-bit ALU; results checked against plain integer division.
module tb_alu_div_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid0, in_valid1;
    logic [31:0] dividend, divisor;
    logic        out_ready;

    logic        in_ready0, out_valid0, dz0, co0;
    logic [31:0] quotient0, remainder0, opa0, opb0, res0;
    logic [2:0]  cmd0;
    logic        in_ready1, out_valid1, dz1, co1;
    logic [31:0] quotient1, remainder1, opa1, opb1, res1;
    logic [2:0]  cmd1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // External ALU: SUB for command 1 (carryout = no borrow), ADD otherwise.
    assign res0 = (cmd0 == 3'd1) ? opa0 - opb0 : opa0 + opb0;
    assign co0  = (cmd0 == 3'd1) ? (opa0 >= opb0) : 1'b0;
    assign res1 = (cmd1 == 3'd1) ? opa1 - opb1 : opa1 + opb1;
    assign co1  = (cmd1 == 3'd1) ? (opa1 >= opb1) : 1'b0;

    alu_div_sequencer #(.ALU_WAIT(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid0), .out_ready(out_ready),
        .quotient(quotient0), .remainder(remainder0), .div_by_zero(dz0),
        .alu_operandA(opa0), .alu_operandB(opb0), .alu_command(cmd0),
        .alu_result(res0), .alu_carryout(co0)
    );

    alu_div_sequencer #(.ALU_WAIT(3)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .dividend(dividend), .divisor(divisor), .out_valid(out_valid1), .out_ready(out_ready),
        .quotient(quotient1), .remainder(remainder1), .div_by_zero(dz1),
        .alu_operandA(opa1), .alu_operandB(opb1), .alu_command(cmd1),
        .alu_result(res1), .alu_carryout(co1)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic dz);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
    endtask

    // Called and returns one time unit after a rising edge.
    task automatic run_div(input bit sel, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output logic dz,
                           output int lat, output bit cmd_ok);
        int n = 0;
        while (!(sel ? in_ready1 : in_ready0) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 300) timeout("in_ready");
        dividend = a;
        divisor  = b;
        if (sel) in_valid1 = 1'b1; else in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
        lat = 0;
        cmd_ok = 1'b1;
        while (!(sel ? out_valid1 : out_valid0) && lat < 2000) begin
            if ((sel ? cmd1 : cmd0) != 3'd1) cmd_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        if (lat >= 2000) timeout("out_valid");
        if ((sel ? cmd1 : cmd0) != 3'd1) cmd_ok = 1'b0;
        q  = sel ? quotient1 : quotient0;
        r  = sel ? remainder1 : remainder0;
        dz = sel ? dz1 : dz0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q, r, eq, er, a, b;
        logic        dz, edz;
        int          lat, n;
        bit          cmd_ok;

        vecs.push_back('{32'd100,        32'd7,          32'd14,         32'd2,          1'b0});
        vecs.push_back('{32'hFFFF_FFFF,  32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1'b0});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0});
        vecs.push_back('{32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1});
        vecs.push_back('{32'd0,          32'd5,          32'd0,          32'd0,          1'b0});
        vecs.push_back('{32'd7,          32'd100,        32'd0,          32'd7,          1'b0});
        vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0});
        vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0});
        vecs.push_back('{32'hFFFF_FFFE,  32'h7FFF_FFFF,  32'd2,          32'd0,          1'b0});

        reset_n = 1'b0; in_valid0 = 1'b0; in_valid1 = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        #12;
        check("rst_in_ready",  32'(in_ready0),  32'd1);
        check("rst_out_valid", 32'(out_valid0), 32'd0);
        check("rst_quotient",  quotient0,       32'd0);
        check("rst_remainder", remainder0,      32'd0);
        check("rst_dz",        32'(dz0),        32'd0);
        check("rst_opa",       opa0,            32'd0);
        check("rst_opb",       opb0,            32'd0);
        check("rst_cmd",       32'(cmd0),       32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_div(1'b0, vecs[i].a, vecs[i].b, q, r, dz, lat, cmd_ok);
            check($sformatf("vec%0d_quotient", i),  q,         vecs[i].q);
            check($sformatf("vec%0d_remainder", i), r,         vecs[i].r);
            check($sformatf("vec%0d_dz", i),        32'(dz),   32'(vecs[i].dz));
            check($sformatf("vec%0d_latency", i),   32'(lat),  (vecs[i].b == 0) ? 32'd0 : 32'd64);
            check($sformatf("vec%0d_cmd", i),       32'(cmd_ok), 32'd1);
        end

        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 255);
                2:       b = $urandom;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            ref_div(a, b, eq, er, edz);
            run_div(1'b0, a, b, q, r, dz, lat, cmd_ok);
            check($sformatf("rnd%0d_quotient", i),  q,       eq);
            check($sformatf("rnd%0d_remainder", i), r,       er);
            check($sformatf("rnd%0d_dz", i),        32'(dz), 32'(edz));
        end

        run_div(1'b1, 32'd100, 32'd7, q, r, dz, lat, cmd_ok);
        check("w3_quotient",  q,           32'd14);
        check("w3_remainder", r,           32'd2);
        check("w3_dz",        32'(dz),     32'd0);
        check("w3_latency",   32'(lat),    32'd128);
        check("w3_cmd",       32'(cmd_ok), 32'd1);

        // Consumer back-pressure with a stray request while busy.
        dividend = 32'd1000; divisor = 32'd10; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        n = 0;
        while (!out_valid0 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) timeout("stall_out_valid");
        for (int i = 0; i < 10; i++) begin
            check("stall_quotient",  quotient0,        32'd100);
            check("stall_remainder", remainder0,       32'd0);
            check("stall_out_valid", 32'(out_valid0),  32'd1);
            check("stall_in_ready",  32'(in_ready0),   32'd0);
            check("stall_dz",        32'(dz0),         32'd0);
            if (i == 4) begin dividend = 32'd50; divisor = 32'd0; in_valid0 = 1'b1; end
            if (i == 5) in_valid0 = 1'b0;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_in_ready",  32'(in_ready0),  32'd1);
        check("post_hs_out_valid", 32'(out_valid0), 32'd0);
        check("idle_hold_quot",    quotient0,       32'd100);
        check("idle_hold_rem",     remainder0,      32'd0);

        // Reset in the middle of a division.
        dividend = 32'd123456; divisor = 32'd789; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready",  32'(in_ready0),  32'd1);
        check("midrst_out_valid", 32'(out_valid0), 32'd0);
        check("midrst_quotient",  quotient0,       32'd0);
        check("midrst_remainder", remainder0,      32'd0);
        check("midrst_dz",        32'(dz0),        32'd0);
        check("midrst_opa",       opa0,            32'd0);
        check("midrst_opb",       opb0,            32'd0);
        check("midrst_cmd",       32'(cmd0),       32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            if (out_valid0) check("midrst_no_valid", 32'(out_valid0), 32'd0);
            @(posedge clk); #1;
        end
        run_div(1'b0, 32'd9, 32'd3, q, r, dz, lat, cmd_ok);
        check("after_rst_quotient",  q,        32'd3);
        check("after_rst_remainder", r,        32'd0);
        check("after_rst_latency",   32'(lat), 32'd64);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_div_sequencer.md
ALU_DIV_SEQUENCER -- requirements
Module: alu_div_sequencer

Interface
REQ-001 SHALL have parameter ALU_WAIT, default 1, meaning the number of cycles the external ALU inputs are held before its outputs are sampled (legal range 1..15).
REQ-002 SHALL have one clock, `clk`; reset is asynchronous and active-low, `reset_n`.
REQ-003 Ports, in order:
- clk  in  1  rising-edge clock
- reset_n  in  1  async active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- dividend  in  32  unsigned dividend
- divisor  in  32  unsigned divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- quotient  out  32  unsigned quotient
- remainder  out  32  unsigned remainder
- div_by_zero  out  1  divisor was zero
- alu_operandA  out  32  drives operandA of the external 32-bit ALU
- alu_operandB  out  32  drives operandB of the external ALU
- alu_command  out  3  drives command of the external ALU
- alu_result  in  32  external ALU result
- alu_carryout  in  1  external ALU carryout (1 = no borrow on SUB)

Function
REQ-004 SHALL implement unsigned 32-bit restoring division, using only the external ALU for subtraction.
REQ-005 SHALL use the states IDLE, LOAD, WAIT and DONE.
REQ-006 in_ready SHALL be 1 only in IDLE.
REQ-007 A request SHALL be accepted on the edge where in_valid && in_ready; requests are never overlapped.
REQ-008 On accept with divisor != 0, the block SHALL latch dividend and divisor, set the working remainder to 0 and the bit index to 31, and go to LOAD.
REQ-009 On accept with divisor == 0, the block SHALL go directly to DONE with quotient=32'hFFFFFFFF, remainder=dividend and div_by_zero=1; out_valid is high on the cycle after accept.
REQ-010 On the LOAD->WAIT edge, the block SHALL register:
- alu_operandA = {rem[30:0], dvd[bit]}
- alu_operandB = divisor
- alu_command = 3'd1 (SUB)
- the pre-shift bit rem[31] into a flag
REQ-011 The block SHALL stay in WAIT for exactly ALU_WAIT cycles and sample alu_result/alu_carryout on the last WAIT edge.
REQ-012 Capture rule:
- If (alu_carryout || saved rem[31]): rem <= alu_result and q[bit] <= 1.
- Else: rem <= alu_operandA and q[bit] <= 0.
- alu_result is taken modulo 2^32.
REQ-013 After capture, if bit==0 the block SHALL go to DONE; otherwise it SHALL decrement bit and go to LOAD.
REQ-014 Per-bit cost SHALL be 1+ALU_WAIT cycles; out_valid SHALL rise 32*(1+ALU_WAIT) cycles after the accept edge (64 for ALU_WAIT=1).
REQ-015 In DONE, out_valid SHALL be 1 and quotient/remainder/div_by_zero SHALL be held stable until the edge where out_valid && out_ready; that edge returns the block to IDLE.
REQ-016 quotient/remainder/div_by_zero SHALL keep their last values in IDLE; div_by_zero SHALL be cleared on the next accept.
REQ-017 alu_operandA/B SHALL change only on LOAD->WAIT edges and alu_command SHALL be 3'd1 whenever state != IDLE; the ALU outputs zero, overflow and the other ALU commands are unused.
REQ-018 in_valid asserted while busy SHALL be ignored with no side effect.

Reset
REQ-019 Asserting reset_n low SHALL immediately force, independent of clk:
- state to IDLE
- out_valid, quotient, remainder, div_by_zero, alu_operandA, alu_operandB, alu_command and all internal registers to 0
- in_ready to 1
REQ-020 Reset asserted mid-division SHALL abort the operation with no out_valid pulse; the first request after reset_n rises SHALL be processed normally.

Verification
REQ-021 The bench SHALL cover the following directed scenarios (ALU_WAIT=1, real 32-bit ALU attached):
- 100/7 -> quotient=14, remainder=2, div_by_zero=0, out_valid exactly 64 cycles after accept; alu_command==3'd1 throughout.
- 0xFFFFFFFF/0x80000000 -> quotient=1, remainder=0x7FFFFFFF (exercises the rem[31] rule); 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- 5/0 -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, out_valid on the cycle after accept.
- 1000/10 with out_ready held 0 for 10 cycles after out_valid -> outputs stable at 100/0, in_ready=0, a second in_valid during this window is ignored; one cycle after the out_ready handshake -> in_ready=1.
- reset_n pulsed low 20 cycles into 123456/789 -> all outputs 0 and in_ready=1 immediately, no out_valid; a following 9/3 -> quotient=3, remainder=0.
- Same 100/7 with ALU_WAIT=3 -> identical results, out_valid 128 cycles after accept.
